// File: rtl/fault_detect_multi.sv
// Multi-channel fault qualifier: synchronises raw fault inputs, applies
// polarity/mask, qualifies on a 1 us tick count, and latches or auto-recovers.
// Also reports an aggregate fault and the first channel to trip.
module fault_detect_multi #(
  parameter int unsigned CH_NUM  = 8,
  parameter int unsigned CNT_W   = 14,
  parameter int unsigned CH_ID_W = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      time_1us,
  input  logic                      reset_unit,
  input  logic [CH_NUM-1:0]         clear_ch,
  input  logic [CH_NUM-1:0]         signal_in,
  input  logic [CH_NUM-1:0]         active_level,
  input  logic [CH_NUM-1:0]         mask,
  input  logic [CH_NUM-1:0]         latch_mode,
  input  logic [CH_NUM*CNT_W-1:0]   delay_tims,
  input  logic [CNT_W-1:0]          recover_tims,
  output logic [CH_NUM-1:0]         fault_out,
  output logic                      fault_any,
  output logic                      first_fault_valid,
  output logic [CH_ID_W-1:0]        first_fault_id
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // tsync[0] is the first synchroniser stage, tsync[1] the second
  logic [1:0]                          tsync_q, tsync_d;
  logic [CH_NUM-1:0]                   sync1_q, sync1_d;
  logic [CH_NUM-1:0]                   sync2_q, sync2_d;
  logic [CH_NUM-1:0][CNT_W-1:0]        acnt_q, acnt_d;
  logic [CH_NUM-1:0][CNT_W-1:0]        rcnt_q, rcnt_d;
  logic [CH_NUM-1:0]                   fault_q, fault_d;
  logic                                fault_any_q, fault_any_d;
  logic                                first_fault_valid_q, first_fault_valid_d;
  logic [CH_ID_W-1:0]                  first_fault_id_q, first_fault_id_d;

  logic                                tick;
  logic [CH_NUM-1:0]                   act;
  logic [CH_NUM-1:0]                   rise;
  logic                                found;

  // Synchroniser next-state, tick on the falling edge of the synchronised timebase
  always_comb begin
    tsync_d = {tsync_q[0], time_1us};
    sync1_d = signal_in;
    sync2_d = sync1_q;
    tick    = tsync_q[1] & ~tsync_q[0];
    act     = ~(sync2_q ^ active_level) & ~mask;
  end

  // Per-channel counters and fault state, in priority order
  always_comb begin
    acnt_d  = acnt_q;
    rcnt_d  = rcnt_q;
    fault_d = fault_q;
    for (int unsigned c = 0; c < CH_NUM; c++) begin
      if (!act[c]) begin
        acnt_d[c] = '0;
      end else if (tick && (acnt_q[c] != CNT_MAX)) begin
        acnt_d[c] = acnt_q[c] + 1'b1;
      end

      if (act[c] || !fault_q[c]) begin
        rcnt_d[c] = '0;
      end else if (tick && (rcnt_q[c] != CNT_MAX)) begin
        rcnt_d[c] = rcnt_q[c] + 1'b1;
      end

      if (reset_unit || mask[c]) begin
        acnt_d[c]  = '0;
        rcnt_d[c]  = '0;
        fault_d[c] = 1'b0;
      end else if (clear_ch[c]) begin
        acnt_d[c]  = '0;
        fault_d[c] = 1'b0;
      end else if (act[c] && (acnt_q[c] >= delay_tims[c*CNT_W +: CNT_W])) begin
        fault_d[c] = 1'b1;
      end else if (!latch_mode[c] && fault_q[c] && (rcnt_q[c] >= recover_tims)) begin
        fault_d[c] = 1'b0;
      end
    end
  end

  // Aggregate fault and first-fault capture (lowest index among same-cycle risers)
  always_comb begin
    fault_any_d         = |fault_q;
    first_fault_valid_d = first_fault_valid_q;
    first_fault_id_d    = first_fault_id_q;
    rise                = fault_d & ~fault_q;
    found               = 1'b0;
    if (reset_unit) begin
      first_fault_valid_d = 1'b0;
      first_fault_id_d    = '0;
    end else if (!first_fault_valid_q && (|rise)) begin
      first_fault_valid_d = 1'b1;
      for (int unsigned c = 0; c < CH_NUM; c++) begin
        if (rise[c] && !found) begin
          first_fault_id_d = CH_ID_W'(c);
          found            = 1'b1;
        end
      end
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tsync_q             <= '0;
      sync1_q             <= '0;
      sync2_q             <= '0;
      acnt_q              <= '0;
      rcnt_q              <= '0;
      fault_q             <= '0;
      fault_any_q         <= 1'b0;
      first_fault_valid_q <= 1'b0;
      first_fault_id_q    <= '0;
    end else begin
      tsync_q             <= tsync_d;
      sync1_q             <= sync1_d;
      sync2_q             <= sync2_d;
      acnt_q              <= acnt_d;
      rcnt_q              <= rcnt_d;
      fault_q             <= fault_d;
      fault_any_q         <= fault_any_d;
      first_fault_valid_q <= first_fault_valid_d;
      first_fault_id_q    <= first_fault_id_d;
    end
  end

  assign fault_out         = fault_q;
  assign fault_any         = fault_any_q;
  assign first_fault_valid = first_fault_valid_q;
  assign first_fault_id    = first_fault_id_q;

endmodule
